// File: rtl/ram_arbiter.sv
// Round-robin arbiter merging REQ ready/valid requesters onto a single
// flip-flop RAM port. Outstanding reads carry a requester tag so each read
// response is returned to the requester that issued it, for either RAM
// output mode (same-cycle or registered rdata).
module ram_arbiter #(
  parameter int DATA   = 16,
  parameter int DEPTH  = 4,
  parameter int REQ    = 4,
  parameter int OUTREG = 0,
  parameter int ADDR   = $clog2(DEPTH),
  parameter int REQW   = $clog2(REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ-1:0]            req_valid,
  input  logic [REQ-1:0]            req_rw_,
  input  logic [REQ-1:0][ADDR-1:0]  req_addr,
  input  logic [REQ-1:0][DATA-1:0]  req_wdata,
  output logic [REQ-1:0]            req_ready,
  output logic [REQ-1:0]            rsp_valid,
  output logic [REQ-1:0][DATA-1:0]  rsp_rdata,
  output logic                      ram_en_,
  output logic                      ram_rw_,
  output logic [ADDR-1:0]           ram_addr,
  output logic [DATA-1:0]           ram_wdata,
  input  logic [DATA-1:0]           ram_rdata,
  output logic                      busy
);

  // Priority pointer and tag stage 0 (the tag of a read just issued).
  logic [REQW-1:0]            ptr_q, ptr_d;
  logic                       tag0_v_q, tag0_v_d;
  logic [REQW-1:0]            tag0_id_q, tag0_id_d;
  // Response output register (final pipeline stage).
  logic [REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [REQ-1:0][DATA-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                       grant_s;
  logic [REQW-1:0]            win_s;
  logic                       rd_grant_s;

  // Round-robin scan from ptr_q, wrapping at REQ-1; first valid requester wins.
  always_comb begin
    int unsigned idx;
    grant_s = 1'b0;
    win_s   = {REQW{1'b0}};
    idx     = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = (int'(ptr_q) + k) % REQ;
      if (!grant_s && req_valid[idx]) begin
        grant_s = 1'b1;
        win_s   = idx[REQW-1:0];
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // One-hot ready for the winner and direct RAM drive in the grant cycle.
  always_comb begin
    req_ready  = {REQ{1'b0}};
    for (int i = 0; i < REQ; i++) begin
      req_ready[i] = grant_s && (win_s == REQW'(i));
    end
    if (grant_s) begin
      ram_en_   = 1'b0;
      ram_rw_   = req_rw_[win_s];
      ram_addr  = req_addr[win_s];
      ram_wdata = req_wdata[win_s];
    end else begin
      ram_en_   = 1'b1;
      ram_rw_   = 1'b1;
      ram_addr  = {ADDR{1'b0}};
      ram_wdata = {DATA{1'b0}};
    end
    rd_grant_s = grant_s && req_rw_[win_s];
  end

  // Next pointer: one past the winner, wrapping for non-power-of-2 REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s) begin
      if (int'(win_s) == REQ - 1) begin
        ptr_d = {REQW{1'b0}};
      end else begin
        ptr_d = win_s + REQW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Tag stage 0 and response capture; rdata is sampled when it is valid at
  // the RAM output: grant cycle (OUTREG=0) or one cycle later (OUTREG=1).
  always_comb begin
    tag0_v_d    = rd_grant_s;
    tag0_id_d   = rd_grant_s ? win_s : {REQW{1'b0}};
    rsp_valid_d = {REQ{1'b0}};
    rsp_rdata_d = {REQ*DATA{1'b0}};
    if (OUTREG == 0) begin
      if (rd_grant_s) begin
        rsp_valid_d[win_s] = 1'b1;
        rsp_rdata_d[win_s] = ram_rdata;
      end else begin
        rsp_valid_d = {REQ{1'b0}};
      end
    end else begin
      if (tag0_v_q) begin
        rsp_valid_d[tag0_id_q] = 1'b1;
        rsp_rdata_d[tag0_id_q] = ram_rdata;
      end else begin
        rsp_valid_d = {REQ{1'b0}};
      end
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= {REQW{1'b0}};
      tag0_v_q    <= 1'b0;
      tag0_id_q   <= {REQW{1'b0}};
      rsp_valid_q <= {REQ{1'b0}};
      rsp_rdata_q <= {REQ*DATA{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      tag0_v_q    <= tag0_v_d;
      tag0_id_q   <= tag0_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    busy      = tag0_v_q | (|rsp_valid_q);
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin access arbiter placed directly upstream of the flip-flop RAM.
- Merges REQ independent requesters onto one RAM read/write port.
- Uses ready/valid handshakes on the requester side and drives the RAM's active-low en_/rw_ interface.
- Tracks outstanding reads in a tag pipeline and routes each read response to the requester that issued it, for either RAM output mode (OUTREG off/on).

Parameters:
- DATA, 16: data width; must match RAM DATA.
- DEPTH, 4: RAM depth.
- REQ, 4: number of requesters; legal range 2..16.
- OUTREG, 0: must match RAM OUTREG. Sets RAM read latency: 0 = same-cycle rdata, 1 = rdata one cycle later.
- ADDR, $clog2(DEPTH): address width (derived).
- REQW, $clog2(REQ): requester index width (derived).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- req_valid  input  [REQ]  requester i presents a command
- req_rw_  input  [REQ]  command type: 1 = read, 0 = write
- req_addr  input  [REQ][ADDR]  command address
- req_wdata  input  [REQ][DATA]  write data
- req_ready  output  [REQ]  command accepted this cycle (one-hot or zero)
- rsp_valid  output  [REQ]  read data valid for requester i (one-hot or zero)
- rsp_rdata  output  [REQ][DATA]  read data; 0 when the matching rsp_valid is low
- ram_en_  output  1  to RAM en_ (active low)
- ram_rw_  output  1  to RAM rw_
- ram_addr  output  [ADDR]  to RAM addr
- ram_wdata  output  [DATA]  to RAM wdata
- ram_rdata  input  [DATA]  from RAM rdata
- busy  output  1  a read is in flight in the tag pipeline

Behaviour:
- Arbitration (combinational from current state):
  - Scan req_valid starting at priority pointer ptr, wrapping REQ-1 -> 0. The first valid requester wins.
  - Winner w gets req_ready[w]=1; a transfer occurs when req_valid[w] & req_ready[w].
  - At most one grant per cycle. req_ready is 0 for all requesters when none are valid.
  - req_ready does not depend on req_ready of other requesters; there is no backpressure from the RAM side.
- Pointer:
  - On a grant, ptr <= (w+1) mod REQ (wraps, REQ need not be a power of 2).
  - No grant: ptr holds.
  - Reset value 0.
- RAM drive (same cycle as grant):
  - ram_en_=0, ram_rw_=req_rw_[w], ram_addr=req_addr[w], ram_wdata=req_wdata[w].
  - No grant: ram_en_=1, ram_rw_=1, ram_addr=0, ram_wdata=0.
- Tag pipeline:
  - Depth 1+OUTREG, each stage holds {valid, id[REQW]}.
  - Stage 0 loads {1, w} on a read grant and {0, 0} otherwise. Write grants carry no tag.
  - OUTREG=0: ram_rdata is sampled in the grant cycle together with the tag.
  - OUTREG=1: the tag advances one stage, and ram_rdata is sampled as the tag leaves stage 0.
- Response:
  - Registered output. rsp_valid[id]=1 and rsp_rdata[id]=captured data for exactly one cycle.
  - Latency from grant edge to rsp_valid: 1 cycle for OUTREG=0, 2 cycles for OUTREG=1.
  - Back-to-back reads give back-to-back responses in grant order. Throughput is 1 command per cycle.
- busy = OR of tag valid bits and output-stage valid.
- Ordering:
  - A write granted in cycle t is visible to a read granted in t+1 (the RAM writes on the edge).
  - Same-cycle read/write conflict cannot occur (single grant).
- Reset (asynchronous assert, any cycle, including mid-read):
  - ptr=0, all tags invalid, rsp_valid=0, rsp_rdata=0.
  - The in-flight read is dropped with no response after reset release.
  - Combinational outputs follow the reset-state pointer immediately.
- req_valid may drop without a grant; the requester is not required to hold it.
- req_* must be stable while req_valid=1 and not granted. Violation is a requester error; the arbiter samples whatever is present at grant.

Test Plan:
- Single read, OUTREG=0, RAM preloaded with mem[2]=16'hBEEF: req 1 reads addr 2 at cycle 0 -> req_ready[1]=1 at cycle 0, ram_en_=0, ram_rw_=1; rsp_valid[1]=1 and rsp_rdata[1]=BEEF at cycle 1 only.
- All 4 requesters hold valid reads continuously from ptr=0 -> grant order 0,1,2,3,0,1...; one grant per cycle; each rsp arrives at its grant+1; no requester waits more than 3 cycles.
- OUTREG=1, req 3 writes 16'h1234 to addr 1 at cycle 0 and reads addr 1 at cycle 1 -> read returns 1234 on rsp_valid[3] at cycle 3; no response for the write.
- Sparse traffic: only req 2 valid at cycle 0 with ptr=0 -> grant 2, ptr=3; next, req 0 and req 3 both valid -> req 3 wins, then ptr wraps to 0 and req 0 wins.
- Reset asserted with OUTREG=1 while a read is in stage 0 -> rsp_valid stays 0 through and after reset, busy=0, ptr=0; the first post-reset grant goes to the lowest-index valid requester.
- No valid requests for 10 cycles -> ram_en_=1 throughout, req_ready=0, rsp_valid=0, busy=0, ptr unchanged.
